// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch and data stage) in front of one single-port memory.
// Data wins by default; a saturating starve counter forces a fetch grant after STARVE_MAX data wins.
module mem_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk_20,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,

    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;

    logic        m_en_q, m_en_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        if_unmasked;
    logic        d_unmasked;
    logic        grant_d;
    logic        grant_i;

    // A requester whose done pulse is showing is still holding its old request; ignore it.
    assign if_unmasked = if_req & ~if_done_q;
    assign d_unmasked  = d_req  & ~d_done_q;

    assign grant_d = (state_q == IDLE) && d_unmasked &&
                     (!if_unmasked || (starve_q != STARVE_LIM));
    assign grant_i = (state_q == IDLE) && if_unmasked && !grant_d;

    // State register
    always_ff @(posedge clk_20) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state and starvation bookkeeping
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERVE_D;
                end else if (grant_i) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (m_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_i) begin
            starve_d = 4'd0;
        end else if (grant_d && if_unmasked && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Registered outputs: memory command launched on grant, retired on ack
    always_comb begin
        m_en_d     = m_en_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    m_en_d    = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (grant_i) begin
                    m_en_d    = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = 32'd0;
                end
            end
            SERVE_I: begin
                if (m_ack) begin
                    m_en_d     = 1'b0;
                    m_we_d     = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = m_rdata;
                end
            end
            SERVE_D: begin
                if (m_ack) begin
                    m_en_d   = 1'b0;
                    m_we_d   = 1'b0;
                    d_done_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end
            default: begin
                m_en_d = 1'b0;
                m_we_d = 1'b0;
            end
        endcase
    end

    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, starvation, wait states, reset, stray ack.
module tb_mem_arbiter;

    logic        clk_20 = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_20 = ~clk_20;

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk_20   (clk_20),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack)
    );

    task automatic tick();
        @(posedge clk_20);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vector %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

    initial begin
        logic [31:0] g_addr [5];
        logic [3:0]  g_starve [5];
        logic [31:0] exp_addr [5];
        int          ngrant;
        logic        prev_en;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_m_en", 32'(m_en), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        // Single fetch, zero wait states
        if_req = 1'b1; if_addr = 32'h40; m_ack = 1'b1; m_rdata = 32'h8C010004;
        tick();
        chk("f_m_en", 32'(m_en), 32'd1);
        chk("f_m_addr", m_addr, 32'h40);
        chk("f_m_we", 32'(m_we), 32'd0);
        chk("f_if_done_early", 32'(if_done), 32'd0);
        tick();
        chk("f_if_done", 32'(if_done), 32'd1);
        chk("f_m_en_off", 32'(m_en), 32'd0);
        chk("f_if_rdata", if_rdata, 32'h8C010004);
        if_req = 1'b0;
        tick();
        chk("f_if_done_one", 32'(if_done), 32'd0);

        // Stray ack in IDLE
        m_ack = 1'b1; m_rdata = 32'h12345678;
        tick(); tick();
        chk("stray_m_en", 32'(m_en), 32'd0);
        chk("stray_if_done", 32'(if_done), 32'd0);
        chk("stray_d_done", 32'(d_done), 32'd0);
        chk("stray_if_rdata", if_rdata, 32'h8C010004);

        // Simultaneous requests: data write first, fetch granted in the d_done cycle
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h80; m_rdata = 32'h11112222;
        tick();
        chk("sim_m_en", 32'(m_en), 32'd1);
        chk("sim_m_we", 32'(m_we), 32'd1);
        chk("sim_m_addr", m_addr, 32'h100);
        chk("sim_m_wdata", m_wdata, 32'hDEADBEEF);
        tick();
        chk("sim_d_done", 32'(d_done), 32'd1);
        chk("sim_m_en_off", 32'(m_en), 32'd0);
        chk("sim_d_rdata_keep", d_rdata, 32'd0);
        d_req = 1'b0; m_rdata = 32'h33334444;
        tick();
        chk("sim_i_m_en", 32'(m_en), 32'd1);
        chk("sim_i_m_addr", m_addr, 32'h80);
        chk("sim_i_m_we", 32'(m_we), 32'd0);
        chk("sim_d_done_one", 32'(d_done), 32'd0);
        tick();
        chk("sim_if_done", 32'(if_done), 32'd1);
        chk("sim_if_rdata", if_rdata, 32'h33334444);
        chk("sim_d_rdata_keep2", d_rdata, 32'd0);
        if_req = 1'b0;
        tick();

        // Data read with four wait states
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; m_ack = 1'b0; m_rdata = 32'hCAFEF00D;
        tick();
        chk("ws_m_en_0", 32'(m_en), 32'd1);
        chk("ws_m_addr_0", m_addr, 32'h200);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("ws_m_en_%0d", i), 32'(m_en), 32'd1);
            chk($sformatf("ws_m_addr_%0d", i), m_addr, 32'h200);
            chk($sformatf("ws_d_done_%0d", i), 32'(d_done), 32'd0);
        end
        m_ack = 1'b1;
        tick();
        chk("ws_d_done", 32'(d_done), 32'd1);
        chk("ws_m_en_off", 32'(m_en), 32'd0);
        chk("ws_d_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0; m_ack = 1'b0;
        tick();
        chk("ws_d_done_one", 32'(d_done), 32'd0);

        // Reset in the middle of a data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h5555AAAA;
        tick();
        chk("rs_m_en", 32'(m_en), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs_m_en_off", 32'(m_en), 32'd0);
        chk("rs_m_we", 32'(m_we), 32'd0);
        chk("rs_m_addr", m_addr, 32'd0);
        chk("rs_m_wdata", m_wdata, 32'd0);
        chk("rs_d_done", 32'(d_done), 32'd0);
        chk("rs_d_rdata", d_rdata, 32'd0);
        chk("rs_if_rdata", if_rdata, 32'd0);
        tick();
        chk("rs_re_m_en", 32'(m_en), 32'd1);
        chk("rs_re_m_addr", m_addr, 32'h300);
        chk("rs_re_d_done", 32'(d_done), 32'd0);
        m_ack = 1'b1;
        tick();
        chk("rs_re_done", 32'(d_done), 32'd1);
        d_req = 1'b0; m_ack = 1'b0;
        tick();

        // Starvation: data held, fetch withdraws only while d_done shows
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; if_addr = 32'h500;
        m_ack = 1'b1; m_rdata = 32'h0;
        exp_addr[0] = 32'h400; exp_addr[1] = 32'h400; exp_addr[2] = 32'h400;
        exp_addr[3] = 32'h500; exp_addr[4] = 32'h400;
        ngrant = 0;
        prev_en = 1'b0;
        for (int c = 0; c < 60 && ngrant < 5; c++) begin
            if_req = !d_done;
            tick();
            if (m_en && !prev_en) begin
                g_addr[ngrant]   = m_addr;
                g_starve[ngrant] = dut.starve_q;
                ngrant++;
            end
            prev_en = m_en;
        end
        chk("st_grant_count", 32'(ngrant), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < ngrant) begin
                chk($sformatf("st_grant_%0d_addr", i), g_addr[i], exp_addr[i]);
            end
        end
        if (ngrant >= 4) begin
            chk("st_count_at_third_data", 32'(g_starve[2]), 32'd3);
            chk("st_count_after_fetch", 32'(g_starve[3]), 32'd0);
        end
        d_req = 1'b0; if_req = 1'b0; m_ack = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
